operand_fetch: RTL and testbench

Operand-fetch stage between instruction fetch/decode and execute. Presents rs1/rs2 addresses to the block-RAM register file (`regfile`, one-cycle registered read), captures the returned operands and forwards in-flight write-back data. Delivers a complete operand bundle downstream over a valid/ready handshake at up to one instruction per cycle. Also covers the undefined read-during-write behaviour of the iCE40 RAM.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/operand_fetch_if.sv | 36 +++
 rtl/fwd_resolve.sv | 20 ++
 rtl/operand_fetch.sv | 104 ++++++++++
 tb/tb_operand_fetch.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, RV32 field positions and operand bundle type
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int RD_LSB     = 7;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

  typedef struct packed {
    word_t     instr;
    word_t     pc;
    word_t     rs1_val;
    word_t     rs2_val;
    reg_addr_t rd;
  } operand_bundle_t;

  function automatic reg_addr_t rs1_of(input word_t instr);
    return instr[RS1_LSB +: REG_ADDR_W];
  endfunction

  function automatic reg_addr_t rs2_of(input word_t instr);
    return instr[RS2_LSB +: REG_ADDR_W];
  endfunction

  function automatic reg_addr_t rd_of(input word_t instr);
    return instr[RD_LSB +: REG_ADDR_W];
  endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - upstream, regfile, write-back and downstream signals of the stage
interface operand_fetch_if import riscv_pkg::*; ();
  logic      flush;
  logic      in_valid;
  logic      in_ready;
  word_t     in_instr;
  word_t     in_pc;
  reg_addr_t rf_rdAddrA;
  reg_addr_t rf_rdAddrB;
  word_t     rf_rdDataA;
  word_t     rf_rdDataB;
  logic      wb_write;
  reg_addr_t wb_addr;
  word_t     wb_data;
  logic      out_valid;
  logic      out_ready;
  word_t     out_instr;
  word_t     out_pc;
  word_t     out_rs1Val;
  word_t     out_rs2Val;
  reg_addr_t out_rd;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, rf_rdDataA, rf_rdDataB,
    input  wb_write, wb_addr, wb_data, out_ready,
    output in_ready, rf_rdAddrA, rf_rdAddrB,
    output out_valid, out_instr, out_pc, out_rs1Val, out_rs2Val, out_rd
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, rf_rdDataA, rf_rdDataB,
    output wb_write, wb_addr, wb_data, out_ready,
    input  in_ready, rf_rdAddrA, rf_rdAddrB,
    input  out_valid, out_instr, out_pc, out_rs1Val, out_rs2Val, out_rd
  );
endinterface

// File: rtl/fwd_resolve.sv
// rtl/fwd_resolve.sv - per-operand priority: x0, live write-back, last write-back, RAM data
module fwd_resolve import riscv_pkg::*; (
  input  reg_addr_t rs,
  input  logic      wb_write,
  input  reg_addr_t wb_addr,
  input  word_t     wb_data,
  input  logic      wbq_v,
  input  reg_addr_t wbq_addr,
  input  word_t     wbq_data,
  input  word_t     rf_data,
  output word_t     val
);
  // rs != 0 here implies the write-back index is nonzero too
  always_comb begin
    if (rs == '0)                            val = '0;
    else if (wb_write && (wb_addr == rs))    val = wb_data;
    else if (wbq_v && (wbq_addr == rs))      val = wbq_data;
    else                                     val = rf_data;
  end
endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - two-slot operand fetch: slot A awaits RAM data, slot B drives the outputs
module operand_fetch import riscv_pkg::*; (
  input logic             clk,
  input logic             rst_n,
  operand_fetch_if.slave  bus
);
  logic            a_valid_q, a_valid_d;
  word_t           a_instr_q, a_instr_d;
  word_t           a_pc_q, a_pc_d;
  logic            b_valid_q, b_valid_d;
  operand_bundle_t bundle_q, bundle_d;
  logic            wbq_v_q, wbq_v_d;
  reg_addr_t       wbq_addr_q, wbq_addr_d;
  word_t           wbq_data_q, wbq_data_d;

  logic  adv_b, adv_a, a_hold, accept, wb_qual;
  word_t rs1_res, rs2_res;

  assign adv_b        = !b_valid_q || bus.out_ready;
  assign adv_a        = a_valid_q && adv_b;
  assign a_hold       = a_valid_q && !adv_a;
  assign bus.in_ready = rst_n && !bus.flush && (!a_valid_q || adv_a);
  assign accept       = bus.in_valid && bus.in_ready;
  assign wb_qual      = bus.wb_write && (bus.wb_addr != '0);

  // A stalled re-reads its own registers so the RAM data stays aligned with A
  assign bus.rf_rdAddrA = a_hold ? rs1_of(a_instr_q) : rs1_of(bus.in_instr);
  assign bus.rf_rdAddrB = a_hold ? rs2_of(a_instr_q) : rs2_of(bus.in_instr);

  fwd_resolve u_fwd_rs1 (
    .rs(rs1_of(a_instr_q)), .wb_write(bus.wb_write), .wb_addr(bus.wb_addr),
    .wb_data(bus.wb_data), .wbq_v(wbq_v_q), .wbq_addr(wbq_addr_q),
    .wbq_data(wbq_data_q), .rf_data(bus.rf_rdDataA), .val(rs1_res)
  );

  fwd_resolve u_fwd_rs2 (
    .rs(rs2_of(a_instr_q)), .wb_write(bus.wb_write), .wb_addr(bus.wb_addr),
    .wb_data(bus.wb_data), .wbq_v(wbq_v_q), .wbq_addr(wbq_addr_q),
    .wbq_data(wbq_data_q), .rf_data(bus.rf_rdDataB), .val(rs2_res)
  );

  always_comb begin
    a_valid_d  = a_valid_q;
    a_instr_d  = a_instr_q;
    a_pc_d     = a_pc_q;
    b_valid_d  = b_valid_q;
    bundle_d   = bundle_q;
    wbq_v_d    = wb_qual;
    wbq_addr_d = bus.wb_addr;
    wbq_data_d = bus.wb_data;
    if (bus.flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      if (accept) begin
        a_valid_d = 1'b1;
        a_instr_d = bus.in_instr;
        a_pc_d    = bus.in_pc;
      end else if (adv_a) begin
        a_valid_d = 1'b0;
      end
      if (adv_a) begin
        b_valid_d = 1'b1;
        bundle_d  = '{instr: a_instr_q, pc: a_pc_q, rs1_val: rs1_res,
                      rs2_val: rs2_res, rd: rd_of(a_instr_q)};
      end else if (b_valid_q && bus.out_ready) begin
        b_valid_d = 1'b0;
      end else if (b_valid_q) begin
        // a held bundle keeps tracking writes to its source registers
        if (wb_qual && (bus.wb_addr == rs1_of(bundle_q.instr))) bundle_d.rs1_val = bus.wb_data;
        if (wb_qual && (bus.wb_addr == rs2_of(bundle_q.instr))) bundle_d.rs2_val = bus.wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid_q  <= 1'b0;
      a_instr_q  <= '0;
      a_pc_q     <= '0;
      b_valid_q  <= 1'b0;
      bundle_q   <= '0;
      wbq_v_q    <= 1'b0;
      wbq_addr_q <= '0;
      wbq_data_q <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_instr_q  <= a_instr_d;
      a_pc_q     <= a_pc_d;
      b_valid_q  <= b_valid_d;
      bundle_q   <= bundle_d;
      wbq_v_q    <= wbq_v_d;
      wbq_addr_q <= wbq_addr_d;
      wbq_data_q <= wbq_data_d;
    end
  end

  assign bus.out_valid  = b_valid_q;
  assign bus.out_instr  = bundle_q.instr;
  assign bus.out_pc     = bundle_q.pc;
  assign bus.out_rs1Val = bundle_q.rs1_val;
  assign bus.out_rs2Val = bundle_q.rs2_val;
  assign bus.out_rd     = bundle_q.rd;
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - randomized bench for operand_fetch against an architectural register model
module tb_operand_fetch;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_fetch_if bus ();
  operand_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  word_t regs [32];

  typedef struct {
    word_t instr;
    word_t pc;
    int    acc;
  } entry_t;
  entry_t q[$];

  // RAM with registered read; a read colliding with a write, or of x0, returns garbage
  function automatic word_t rf_read(reg_addr_t a);
    if (a == '0 || (bus.wb_write && bus.wb_addr == a)) return $urandom;
    return regs[a];
  endfunction

  always @(posedge clk) begin
    bus.rf_rdDataA <= rf_read(bus.rf_rdAddrA);
    bus.rf_rdDataB <= rf_read(bus.rf_rdAddrB);
  end

  function automatic word_t ref_val(reg_addr_t r);
    return (r == '0) ? '0 : regs[r];
  endfunction

  function automatic word_t mk_instr(reg_addr_t rs1, reg_addr_t rs2, reg_addr_t rd);
    word_t i;
    i = $urandom;
    i[19:15] = rs1;
    i[24:20] = rs2;
    i[11:7]  = rd;
    return i;
  endfunction

  task automatic set_idle();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = $urandom;
    bus.in_pc     = $urandom;
    bus.wb_write  = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drive(word_t instr);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = $urandom;
  endtask

  // One clock: sample at the falling edge, check against the model, advance the model
  task automatic cycle();
    logic      exp_v, exp_rdy;
    reg_addr_t ea, eb;
    @(negedge clk);
    exp_v = (q.size() > 0) && (cyc >= q[0].acc + 2);
    compared++;
    if (bus.out_valid !== exp_v) begin
      mismatched++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_v);
    end
    if (exp_v && bus.out_valid === 1'b1) begin
      compared++;
      if (bus.out_instr !== q[0].instr || bus.out_pc !== q[0].pc || bus.out_rd !== q[0].instr[11:7]) begin
        mismatched++;
        $display("FAIL bundle_id cyc=%0d got instr=%h pc=%h rd=%0d exp instr=%h pc=%h", cyc,
                 bus.out_instr, bus.out_pc, bus.out_rd, q[0].instr, q[0].pc);
      end
      compared++;
      if (bus.out_rs1Val !== ref_val(q[0].instr[19:15])) begin
        mismatched++;
        $display("FAIL rs1Val cyc=%0d got=%h exp=%h", cyc, bus.out_rs1Val, ref_val(q[0].instr[19:15]));
      end
      compared++;
      if (bus.out_rs2Val !== ref_val(q[0].instr[24:20])) begin
        mismatched++;
        $display("FAIL rs2Val cyc=%0d got=%h exp=%h", cyc, bus.out_rs2Val, ref_val(q[0].instr[24:20]));
      end
    end
    exp_rdy = rst_n && !bus.flush && (q.size() < 2 || bus.out_ready);
    compared++;
    if (bus.in_ready !== exp_rdy) begin
      mismatched++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_rdy);
    end
    if (rst_n) begin
      ea = (q.size() == 2 && !bus.out_ready) ? q[1].instr[19:15] : bus.in_instr[19:15];
      eb = (q.size() == 2 && !bus.out_ready) ? q[1].instr[24:20] : bus.in_instr[24:20];
      compared++;
      if (bus.rf_rdAddrA !== ea || bus.rf_rdAddrB !== eb) begin
        mismatched++;
        $display("FAIL rf_addr cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, bus.rf_rdAddrA, bus.rf_rdAddrB, ea, eb);
      end
    end
    if (!rst_n) begin
      q.delete();
    end else begin
      if (exp_v && bus.out_ready) void'(q.pop_front());
      if (bus.flush) q.delete();
      else if (bus.in_valid && exp_rdy) q.push_back('{bus.in_instr, bus.in_pc, cyc});
    end
    if (bus.wb_write && bus.wb_addr != '0) regs[bus.wb_addr] = bus.wb_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_outputs_zero(string name);
    compared++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== '0 || bus.out_pc !== '0 ||
        bus.out_rs1Val !== '0 || bus.out_rs2Val !== '0 || bus.out_rd !== '0) begin
      mismatched++;
      $display("FAIL %s got valid=%b instr=%h pc=%h rs1=%h rs2=%h rd=%0d exp all zero", name,
               bus.out_valid, bus.out_instr, bus.out_pc, bus.out_rs1Val, bus.out_rs2Val, bus.out_rd);
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    drive(mk_instr(5'd1, 5'd2, 5'd3));
    cycle();
    check_outputs_zero("reset_outputs");
    compared++;
    if (bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
    rst_n = 1'b1;
    set_idle();
    cycle();
  endtask

  task automatic test_back_to_back();
    word_t ins [3];
    regs[5] = 32'h11;
    regs[6] = 32'h22;
    set_idle();
    for (int i = 0; i < 3; i++) ins[i] = mk_instr(5'd5, 5'd6, 5'(i + 1));
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(ins[k]);
      else bus.in_valid = 1'b0;
      if (k >= 2) begin
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== ins[k-2] ||
            bus.out_rs1Val !== 32'h11 || bus.out_rs2Val !== 32'h22) begin
          mismatched++;
          $display("FAIL b2b_%0d got valid=%b instr=%h rs1=%h rs2=%h exp instr=%h rs1=11 rs2=22", k - 2,
                   bus.out_valid, bus.out_instr, bus.out_rs1Val, bus.out_rs2Val, ins[k-2]);
        end
      end
      cycle();
    end
    set_idle();
    repeat (2) cycle();
  endtask

  task automatic test_forward();
    regs[5] = 32'h11;
    set_idle();
    drive(mk_instr(5'd5, 5'd7, 5'd3));
    bus.wb_write = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD;
    cycle();
    bus.in_valid = 1'b0;
    bus.wb_data  = 32'hBEEF;
    cycle();
    bus.wb_write = 1'b0;
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1Val !== 32'hBEEF) begin
      mismatched++;
      $display("FAIL forward got valid=%b rs1=%h exp valid=1 rs1=beef", bus.out_valid, bus.out_rs1Val);
    end
    repeat (2) cycle();
  endtask

  task automatic test_x0();
    set_idle();
    drive(mk_instr(5'd0, 5'd5, 5'd4));
    bus.wb_write = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    bus.wb_write = 1'b0;
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1Val !== '0) begin
      mismatched++;
      $display("FAIL x0 got valid=%b rs1=%h exp valid=1 rs1=0", bus.out_valid, bus.out_rs1Val);
    end
    repeat (2) cycle();
  endtask

  task automatic test_backpressure();
    word_t i0, i1, i2;
    regs[5] = 32'h11;
    regs[6] = 32'h22;
    i0 = mk_instr(5'd5, 5'd6, 5'd1);
    i1 = mk_instr(5'd6, 5'd6, 5'd2);
    i2 = mk_instr(5'd5, 5'd5, 5'd3);
    set_idle();
    bus.out_ready = 1'b0;
    drive(i0); cycle();
    drive(i1); cycle();
    drive(i2);
    for (int s = 0; s < 4; s++) begin
      bus.wb_write = (s == 1);
      bus.wb_addr  = 5'd6;
      bus.wb_data  = 32'h77;
      compared++;
      if (bus.in_ready !== 1'b0 || bus.rf_rdAddrA !== 5'd6 || bus.rf_rdAddrB !== 5'd6) begin
        mismatched++;
        $display("FAIL stall_%0d got in_ready=%b addr=%0d/%0d exp in_ready=0 addr=6/6", s,
                 bus.in_ready, bus.rf_rdAddrA, bus.rf_rdAddrB);
      end
      cycle();
    end
    bus.wb_write = 1'b0;
    compared++;
    if (bus.out_instr !== i0 || bus.out_rs2Val !== 32'h77) begin
      mismatched++;
      $display("FAIL stall_fwd got instr=%h rs2=%h exp instr=%h rs2=77", bus.out_instr, bus.out_rs2Val, i0);
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_flush();
    word_t ic;
    ic = mk_instr(5'd2, 5'd3, 5'd9);
    set_idle();
    bus.out_ready = 1'b0;
    drive(mk_instr(5'd1, 5'd2, 5'd1)); cycle();
    drive(mk_instr(5'd3, 5'd4, 5'd2)); cycle();
    drive(mk_instr(5'd5, 5'd6, 5'd3));
    bus.flush = 1'b1;
    compared++;
    if (bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready);
    end
    cycle();
    bus.flush = 1'b0;
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid);
    end
    drive(ic); cycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== ic) begin
      mismatched++;
      $display("FAIL flush_refill got valid=%b instr=%h exp valid=1 instr=%h", bus.out_valid, bus.out_instr, ic);
    end
    repeat (2) cycle();
  endtask

  task automatic test_reset_mid();
    set_idle();
    bus.out_ready = 1'b0;
    drive(mk_instr(5'd1, 5'd2, 5'd1)); cycle();
    drive(mk_instr(5'd3, 5'd4, 5'd2)); cycle();
    drive(mk_instr(5'd5, 5'd6, 5'd3));
    rst_n = 1'b0;
    cycle();
    check_outputs_zero("reset_mid_outputs");
    rst_n = 1'b1;
    set_idle();
    repeat (2) cycle();
  endtask

  task automatic test_random();
    set_idle();
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = mk_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      bus.in_pc     = $urandom;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.wb_write  = ($urandom_range(0, 1) != 0);
      bus.wb_addr   = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      bus.flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    set_idle();
    repeat (5) cycle();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    regs[0] = '0;
    set_idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_forward();
    test_x0();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
